key_generator: RTL and testbench
================================

// Module: key_generator
// PURPOSE
//  Sequential RSA key-pair generator. From a seed it derives two distinct half-width primes p, q.
//  It then computes N=p*q, selects public exponent e coprime to phi=(p-1)(q-1), and
//  private exponent d = e^-1 mod phi. Feeds the RSA encrypt/decrypt datapath; runs once per start.
// PARAMETERS
//  WORD_WIDTH  32          width of N, e, d; primes are WORD_WIDTH/2 bits
//  E_INIT      65537       first public-exponent candidate (odd, < 2^(WORD_WIDTH-2))
//  LFSR_TAPS   16'hB400    Galois LFSR feedback mask, WORD_WIDTH/2 bits
// PORTS
//  clk    in   1             single clock; all logic on rising edge
//  rst    in   1             synchronous, active-high reset
//  start  in   1             1-cycle pulse launches generation; sampled only in IDLE/DONE
//  seed   in   WORD_WIDTH/2  LFSR seed, captured on accepted start
//  done   out  1             high when keys valid; held until next accepted start or rst
//  N      out  WORD_WIDTH    modulus p*q
//  e      out  WORD_WIDTH    public exponent
//  d      out  WORD_WIDTH    private exponent, 0 < d < phi
// BEHAVIOUR
//  - Reset: on rst=1 at clk edge: state=IDLE; done, N, e, d, p, q, LFSR cleared to 0. Mid-run reset aborts.
//  - States: IDLE -> GEN_P -> TEST_P -> GEN_Q -> TEST_Q -> MUL -> GCD -> INV [-> CHECK] -> DONE.
//  - Start: in IDLE or DONE, start=1 loads LFSR=seed (seed==0 -> 16'hACE1), clears done, goes GEN_P.
//    start while busy is ignored.
//  - GEN_x: advance LFSR one step; candidate = lfsr | {1'b1,0..,1'b1} (MSB and LSB forced).
//    Each prime is then in [2^(W/2-1)+1, 2^(W/2)-1], so N fits WORD_WIDTH bits.
//  - TEST_x: trial division by odd k=3,5,7.. while k*k <= candidate.
//    Any remainder 0 -> composite -> back to GEN_x. Otherwise prime -> next state.
//    Q additionally rejected (back to GEN_Q) if q==p.
//  - Remainders come from one shared bit-serial restoring divider (WORD_WIDTH cycles per op).
//    No combinational % or / operators on datapath.
//  - MUL: N=p*q, phi=(p-1)*(q-1), full WORD_WIDTH unsigned; single-cycle multiply permitted.
//  - GCD: e starts at E_INIT; Euclid via shared divider. If gcd(e,phi)!=1, e+=2 and repeat.
//  - INV: extended Euclid with signed WORD_WIDTH+2-bit coefficients; if result<0 add phi. d=result.
//  - DONE: done=1, N/e/d stable; outputs change only in DONE (registered, glitch-free).
//  - Latency data-dependent (typ. 10^4-10^6 cycles); fully deterministic for a given seed.
// CONFIGURATION
//  KEYGEN_SELFCHECK_EN defined: CHECK state computes (e*d) mod phi with shared divider.
//    Result==1 -> DONE. Otherwise restart at GEN_P with the current LFSR state (never deadlocks).
//  Undefined: CHECK state absent; INV goes directly to DONE. Port list identical in both builds.
// TESTING
//  1 rst high 20 cycles, seed=16'h11AF, start pulse -> done rises; N=p*q for primes p!=q in [32769,65535].
//    e odd >= 65537, (e*d) mod phi == 1.
//  2 round trip on case 1 keys: m=42 -> c=m^e mod N -> c^d mod N == 42. Repeat for m=1 and m=N-1.
//  3 repeat seed 16'h11AF after second start -> N, e, d bit-identical to case 1.
//    seed=16'h0000 -> completes, same result as seed 16'hACE1.
//  4 start pulses while busy -> ignored; keys equal single-start result.
//    done stays 1 until next start, then drops the following cycle.
//  5 rst asserted mid-TEST_Q -> next cycle done=0, N=e=d=0; fresh start completes normally.
//  6 both builds with/without KEYGEN_SELFCHECK_EN, seeds 16'h11AF/16'h0001/16'hFFFF.
//    Each completes with (e*d) mod phi == 1.

Source files
------------

// File: rtl/key_generator.sv
// Sequential RSA key-pair generator: LFSR prime search, N/phi, e by gcd search, d by extended Euclid.
// Define KEYGEN_SELFCHECK_EN to add a CHECK state that verifies (e*d) mod phi == 1 before DONE.
module key_generator #(
  parameter int                        WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0]     E_INIT     = WORD_WIDTH'(65537),
  parameter logic [WORD_WIDTH/2-1:0]   LFSR_TAPS  = 16'hB400
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WORD_WIDTH/2-1:0]   seed,
  output logic                      done,
  output logic [WORD_WIDTH-1:0]     N,
  output logic [WORD_WIDTH-1:0]     e,
  output logic [WORD_WIDTH-1:0]     d
);
  localparam int W  = WORD_WIDTH;
  localparam int H  = WORD_WIDTH / 2;
  localparam int CW = $clog2(2 * W + 1);
  localparam logic [CW-1:0] W_CNT   = CW'(W);
  localparam logic [H-1:0]  ODD_TOP = {1'b1, {(H-2){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE, GEN_P, TEST_P, GEN_Q, TEST_Q, MUL, GCD, INV,
`ifdef KEYGEN_SELFCHECK_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [H-1:0]          lfsr_q, lfsr_d, p_q, p_d, q_q, q_d, k_q, k_d;
  logic [W-1:0]          ksq_q, ksq_d, nmod_q, nmod_d, ex_q, ex_d, phi_q, phi_d;
  logic [W-1:0]          r0_q, r0_d, r1_q, r1_d;
  logic signed [W+1:0]   t0_q, t0_d, t1_q, t1_d;
  logic                  pend_q, pend_d, done_q, done_d;
  logic [2*W-1:0]        dvd_q, dvd_d;
  logic [W-1:0]          divb_q, divb_d, rem_q, rem_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [W-1:0]          n_out_q, n_out_d, e_out_q, e_out_d, d_out_q, d_out_d;
`ifdef KEYGEN_SELFCHECK_EN
  logic [W-1:0]          dw_q, dw_d;
`endif

  logic                  launch;
  logic [2*W-1:0]        launch_a;
  logic [W-1:0]          launch_b;
  logic [CW-1:0]         launch_n;
  logic [W:0]            trial;
  logic [H-1:0]          lfsr_nx;
  logic [W-1:0]          quo, d_res, phi_nx;
  logic                  div_done;

  assign trial    = {rem_q, dvd_q[2*W-1]};
  assign lfsr_nx  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  assign quo      = dvd_q[W-1:0];
  // Bezout coefficient lies in (-phi, phi), so a W-bit wrap-around add of phi suffices.
  assign d_res    = t0_q[W-1:0] + (t0_q[W+1] ? phi_q : '0);
  assign phi_nx   = W'(p_q - 1'b1) * W'(q_q - 1'b1);
  assign div_done = pend_q && (cnt_q == '0);

  always_comb begin
    state_d = state_q;  lfsr_d = lfsr_q;  p_d = p_q;  q_d = q_q;  k_d = k_q;
    ksq_d = ksq_q;  nmod_d = nmod_q;  ex_d = ex_q;  phi_d = phi_q;
    r0_d = r0_q;  r1_d = r1_q;  t0_d = t0_q;  t1_d = t1_q;
    pend_d = pend_q;  done_d = done_q;  dvd_d = dvd_q;  divb_d = divb_q;
    rem_d = rem_q;  cnt_d = cnt_q;
    n_out_d = n_out_q;  e_out_d = e_out_q;  d_out_d = d_out_q;
`ifdef KEYGEN_SELFCHECK_EN
    dw_d = dw_q;
`endif
    launch = 1'b0;  launch_a = '0;  launch_b = '0;  launch_n = W_CNT;

    // Restoring divider: one quotient bit per cycle, quotient shifts into the dividend register.
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (trial >= {1'b0, divb_q}) begin
        rem_d = trial[W-1:0] - divb_q;
        dvd_d = {dvd_q[2*W-2:0], 1'b1};
      end else begin
        rem_d = trial[W-1:0];
        dvd_d = {dvd_q[2*W-2:0], 1'b0};
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          lfsr_d  = (seed == '0) ? H'(16'hACE1) : seed;
          done_d  = 1'b0;
          state_d = GEN_P;
        end
      end
      GEN_P, GEN_Q: begin
        lfsr_d = lfsr_nx;
        k_d    = H'(3);
        ksq_d  = W'(9);
        if (state_q == GEN_P) begin
          p_d = lfsr_nx | ODD_TOP;  state_d = TEST_P;
        end else begin
          q_d = lfsr_nx | ODD_TOP;  state_d = TEST_Q;
        end
      end
      TEST_P, TEST_Q: begin
        if (div_done) begin
          pend_d = 1'b0;
          if (rem_q == '0) begin
            state_d = (state_q == TEST_P) ? GEN_P : GEN_Q;
          end else begin
            k_d   = k_q + H'(2);
            ksq_d = ksq_q + W'({k_q, 2'b00}) + W'(4);
          end
        end else if (!pend_q) begin
          if (state_q == TEST_Q && q_q == p_q) begin
            state_d = GEN_Q;
          end else if (ksq_q > W'((state_q == TEST_P) ? p_q : q_q)) begin
            state_d = (state_q == TEST_P) ? GEN_Q : MUL;
          end else begin
            launch   = 1'b1;
            launch_a = {W'((state_q == TEST_P) ? p_q : q_q), {W{1'b0}}};
            launch_b = W'(k_q);
          end
        end
      end
      MUL: begin
        nmod_d  = W'(p_q) * W'(q_q);
        phi_d   = phi_nx;
        ex_d    = E_INIT;
        r0_d    = phi_nx;
        r1_d    = E_INIT;
        state_d = GCD;
      end
      GCD: begin
        if (div_done) begin
          pend_d = 1'b0;  r0_d = r1_q;  r1_d = rem_q;
        end else if (!pend_q) begin
          if (r1_q == '0) begin
            if (r0_q == W'(1)) begin
              r0_d = phi_q;  r1_d = ex_q;
              t0_d = '0;     t1_d = {{(W+1){1'b0}}, 1'b1};
              state_d = INV;
            end else begin
              ex_d = ex_q + W'(2);  r0_d = phi_q;  r1_d = ex_q + W'(2);
            end
          end else begin
            launch = 1'b1;  launch_a = {r0_q, {W{1'b0}}};  launch_b = r1_q;
          end
        end
      end
      INV: begin
        if (div_done) begin
          pend_d = 1'b0;  r0_d = r1_q;  r1_d = rem_q;
          t0_d   = t1_q;
          t1_d   = t0_q - $signed({2'b00, quo}) * t1_q;
        end else if (!pend_q) begin
          if (r1_q == '0) begin
`ifdef KEYGEN_SELFCHECK_EN
            dw_d     = d_res;
            launch   = 1'b1;
            launch_a = {{W{1'b0}}, ex_q} * {{W{1'b0}}, d_res};
            launch_b = phi_q;
            launch_n = CW'(2 * W);
            state_d  = CHECK;
`else
            n_out_d = nmod_q;  e_out_d = ex_q;  d_out_d = d_res;
            done_d  = 1'b1;    state_d = DONE;
`endif
          end else begin
            launch = 1'b1;  launch_a = {r0_q, {W{1'b0}}};  launch_b = r1_q;
          end
        end
      end
`ifdef KEYGEN_SELFCHECK_EN
      CHECK: begin
        if (div_done) begin
          pend_d = 1'b0;
          if (rem_q == W'(1)) begin
            n_out_d = nmod_q;  e_out_d = ex_q;  d_out_d = dw_q;
            done_d  = 1'b1;    state_d = DONE;
          end else begin
            state_d = GEN_P;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (launch) begin
      dvd_d = launch_a;  divb_d = launch_b;  rem_d = '0;
      cnt_d = launch_n;  pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;  lfsr_q <= '0;  p_q <= '0;  q_q <= '0;  k_q <= '0;
      ksq_q <= '0;  nmod_q <= '0;  ex_q <= '0;  phi_q <= '0;
      r0_q <= '0;  r1_q <= '0;  t0_q <= '0;  t1_q <= '0;
      pend_q <= 1'b0;  done_q <= 1'b0;  dvd_q <= '0;  divb_q <= '0;
      rem_q <= '0;  cnt_q <= '0;  n_out_q <= '0;  e_out_q <= '0;  d_out_q <= '0;
`ifdef KEYGEN_SELFCHECK_EN
      dw_q <= '0;
`endif
    end else begin
      state_q <= state_d;  lfsr_q <= lfsr_d;  p_q <= p_d;  q_q <= q_d;  k_q <= k_d;
      ksq_q <= ksq_d;  nmod_q <= nmod_d;  ex_q <= ex_d;  phi_q <= phi_d;
      r0_q <= r0_d;  r1_q <= r1_d;  t0_q <= t0_d;  t1_q <= t1_d;
      pend_q <= pend_d;  done_q <= done_d;  dvd_q <= dvd_d;  divb_q <= divb_d;
      rem_q <= rem_d;  cnt_q <= cnt_d;  n_out_q <= n_out_d;  e_out_q <= e_out_d;  d_out_q <= d_out_d;
`ifdef KEYGEN_SELFCHECK_EN
      dw_q <= dw_d;
`endif
    end
  end

  assign done = done_q;
  assign N    = n_out_q;
  assign e    = e_out_q;
  assign d    = d_out_q;
endmodule

// File: tb/tb_key_generator.sv
// Directed + randomized bench for key_generator against an arithmetic RSA key-derivation model.
module tb_key_generator;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] seed;
  logic        done;
  logic [31:0] N, e, d;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  key_generator dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .done(done), .N(N), .e(e), .d(d)
  );

  function automatic logic [15:0] m_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic bit m_prime(input longint unsigned c);
    for (longint unsigned k = 3; k * k <= c; k += 2)
      if (c % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint unsigned m_gcd(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    while (b != 0) begin
      t = a % b;  a = b;  b = t;
    end
    return a;
  endfunction

  function automatic longint m_inv(input longint a, input longint m);
    longint r0, r1, t0, t1, qq, tmp;
    r0 = m;  r1 = a;  t0 = 0;  t1 = 1;
    while (r1 != 0) begin
      qq = r0 / r1;
      tmp = r0 - qq * r1;  r0 = r1;  r1 = tmp;
      tmp = t0 - qq * t1;  t0 = t1;  t1 = tmp;
    end
    if (t0 < 0) t0 += m;
    return t0;
  endfunction

  function automatic longint unsigned m_pow(input longint unsigned b, input longint unsigned x,
                                            input longint unsigned m);
    longint unsigned r;
    r = 1;
    b = b % m;
    while (x != 0) begin
      if (x[0]) r = (r * b) % m;
      b = (b * b) % m;
      x = x >> 1;
    end
    return r;
  endfunction

  task automatic model(input logic [15:0] sd, output logic [31:0] mn, output logic [31:0] me,
                       output logic [31:0] md, output logic [31:0] mphi);
    logic [15:0] s;
    longint unsigned p, q, ph, ee;
    s = (sd == 16'h0) ? 16'hACE1 : sd;
    do begin s = m_step(s); p = 64'(s | 16'h8001); end while (!m_prime(p));
    do begin s = m_step(s); q = 64'(s | 16'h8001); end while (q == p || !m_prime(q));
    ph = (p - 1) * (q - 1);
    ee = 65537;
    while (m_gcd(ph, ee) != 1) ee += 2;
    mn = 32'(p * q);  me = 32'(ee);  mphi = 32'(ph);
    md = 32'(m_inv(longint'(ee), longint'(ph)));
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [15:0] s);
    @(negedge clk);
    seed = s;  start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30000 && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic check_keys(input string tag, input logic [15:0] model_seed);
    logic [31:0] mn, me, md, mphi;
    model(model_seed, mn, me, md, mphi);
    check({tag, "_N"}, 64'(N), 64'(mn));
    check({tag, "_e"}, 64'(e), 64'(me));
    check({tag, "_d"}, 64'(d), 64'(md));
    check({tag, "_ed_mod_phi"}, (64'(e) * 64'(d)) % 64'(mphi), 64'd1);
  endtask

  logic [31:0] n1, e1, d1;
  longint unsigned m;

  initial begin
    rst = 1'b1;  start = 1'b0;  seed = 16'h0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_done", 64'(done), 64'd0);
    check("reset_N", 64'(N), 64'd0);
    check("reset_e", 64'(e), 64'd0);
    check("reset_d", 64'(d), 64'd0);

    pulse(16'h11AF);
    wait_done("c1_done");
    check_keys("c1", 16'h11AF);
    check("c1_e_odd", 64'(e[0]), 64'd1);
    check("c1_e_min", 64'(e >= 32'd65537), 64'd1);
    n1 = N;  e1 = e;  d1 = d;
    check("rt_42", m_pow(m_pow(42, 64'(e), 64'(N)), 64'(d), 64'(N)), 64'd42);
    check("rt_1", m_pow(m_pow(1, 64'(e), 64'(N)), 64'(d), 64'(N)), 64'd1);
    m = 64'(N) - 1;
    check("rt_Nm1", m_pow(m_pow(m, 64'(e), 64'(N)), 64'(d), 64'(N)), m);
    for (int i = 0; i < 3; i++) begin
      m = 64'($urandom) % (64'(N) - 3) + 2;
      check("rt_rand", m_pow(m_pow(m, 64'(e), 64'(N)), 64'(d), 64'(N)), m);
    end

    repeat ($urandom_range(3, 30)) @(negedge clk);
    check("c4_done_hold", 64'(done), 64'd1);
    pulse(16'h11AF);
    check("c4_done_drop", 64'(done), 64'd0);
    check("c3_N_stable_busy", 64'(N), 64'(n1));
    wait_done("c3_done");
    check("c3_N_repeat", 64'(N), 64'(n1));
    check("c3_e_repeat", 64'(e), 64'(e1));
    check("c3_d_repeat", 64'(d), 64'(d1));

    pulse(16'h0000);
    wait_done("c3z_done");
    check_keys("c3_zero_as_ace1", 16'hACE1);

    pulse(16'h0001);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(50, 400)) @(negedge clk);
      if (!done) pulse(16'($urandom));
    end
    wait_done("c4_done");
    check_keys("c4_busy", 16'h0001);

    pulse(16'hFFFF);
    repeat ($urandom_range(300, 3000)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("c5_rst_done", 64'(done), 64'd0);
    check("c5_rst_N", 64'(N), 64'd0);
    check("c5_rst_e", 64'(e), 64'd0);
    check("c5_rst_d", 64'(d), 64'd0);
    rst = 1'b0;
    pulse(16'hFFFF);
    wait_done("c5_done");
    check_keys("c5_ffff", 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
